pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Registered program-counter sequencer for the Gumnut core and its wider-address variants. It holds the PC and computes the next PC from a 4-bit operation code, the zero/carry flags and the branch/jump operands. Beyond plain next-PC selection it adds:
- a parametrised hardware return stack for calls, returns and interrupt return;
- interrupt entry and exit with enable masking;
- save and restore of the zero/carry flags across interrupts;
- a stall/enable input;
- sticky stack error flags.

Parameters:
PC_W, 12, PC and address width in bits.
OFFS_W, 9, branch offset width; two's complement, sign-extended to PC_W.
STACK_DEPTH, 8, number of return-stack entries; power of two, minimum 2.
RESET_PC, 0, PC value after reset.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  advance enable; 0 = hold all state
PCoper_i  in  4  operation select
zero_i  in  1  zero flag
carry_i  in  1  carry flag
offset_i  in  OFFS_W  signed branch offset
addr_i  in  PC_W  jump/call target
ISRaddr_i  in  PC_W  interrupt vector
irq_i  in  1  level interrupt request
irq_ack_o  out  1  one-cycle pulse when an interrupt is taken
PC_o  out  PC_W  current PC (registered)
flags_restore_o  out  1  one-cycle pulse on RETI; flags below are valid
zero_rest_o  out  1  restored zero flag
carry_rest_o  out  1  restored carry flag
in_isr_o  out  1  1 while servicing an interrupt
stack_ovf_o  out  1  sticky overflow
stack_unf_o  out  1  sticky underflow

Behaviour:
Reset (async, rst_ni=0):
- PC_o=RESET_PC.
- Stack pointer = 0 (empty); interrupt enable ie=1.
- All other outputs 0.

Update rule:
- All state updates on rising clk_i, only when en_i=1.
- en_i=0: PC, stack, ie and sticky flags hold; irq is not taken; pulse outputs are 0.

Operations (PCoper_i), where next = PC_o+1 and br = PC_o+sext(offset_i):
- 0000 INC: PC=next.
- 0100 BZ: PC = zero_i ? br : next.
- 0101 BNZ: PC = !zero_i ? br : next.
- 0110 BC: PC = carry_i ? br : next.
- 0111 BNC: PC = !carry_i ? br : next.
- 1000 JMP: PC=addr_i.
- 1001 CALL: push {0,0,next}; PC=addr_i.
- 1010 RET: pop entry; PC = entry PC field.
- 1011 RETI: pop entry; PC = entry PC field; zero_rest_o/carry_rest_o = entry flags; flags_restore_o=1 for one cycle; ie=1; in_isr_o=0.
- Any other code: PC=next.

Arithmetic:
- All PC arithmetic is modulo 2^PC_W. Wrap is silent: 0xFFF+1=0x000 for PC_W=12.
- A negative offset branches backwards.

Interrupt taken when irq_i=1 && ie=1 && en_i=1 && PCoper_i is not CALL/RET/RETI. When taken:
- The normal next PC is computed for the current op, including the branch decision.
- push {zero_i, carry_i, that next PC}; PC=ISRaddr_i.
- ie=0; in_isr_o=1; irq_ack_o=1 for one cycle.

Interrupt deferral and masking:
- If the current op is CALL/RET/RETI, the interrupt is deferred to the next eligible cycle. There is no simultaneous double stack access.
- irq_i held high during an ISR is ignored until RETI. It may be re-taken on the cycle after RETI.

Stack:
- Each entry is PC_W+2 bits wide. Pointer range 0..STACK_DEPTH.
- Push when full: entry is dropped, pointer unchanged, stack_ovf_o set; PC still takes its new value (target or ISR).
- Pop when empty: PC=next; stack_unf_o set; flags_restore_o still pulses on RETI, with zero_rest_o/carry_rest_o=0.
- Sticky flags clear only on reset.

Latency: one cycle. PC_o reflects the operation presented on the preceding enabled edge.

Reset mid-operation (including inside an ISR or with a partially filled stack):
- Everything returns to reset values immediately, asynchronously.
- Stack contents are discarded.

Test Plan:
- Reset, then 3 cycles INC, then BZ offset=-2 with zero_i=1 -> PC_o 0,1,2,3,1; same with zero_i=0 -> 4.
- PC=0xFFE, two INC -> 0xFFF, 0x000; no error flags.
- CALL addr=0x100 from PC=0x010, INC, RET -> PC 0x100, 0x101, 0x011; pointer back to 0.
- At PC=0x020 doing BNC, carry=0, offset=+5, irq_i=1, zero=1, carry=0, ISRaddr=0x800:
  - -> irq_ack_o pulse, PC=0x800, in_isr_o=1.
  - irq held, INC -> PC=0x801 (irq not retaken).
  - RETI -> PC=0x025, flags_restore_o=1, zero_rest_o=1, carry_rest_o=0.
- irq_i=1 with PCoper_i=CALL -> call executes, no ack; next cycle ack and ISR entry; stack holds 2 entries.
- STACK_DEPTH+1 CALLs -> stack_ovf_o=1 after the last; then STACK_DEPTH+1 RETs -> last RET gives PC=next and stack_unf_o=1; both stay 1 until rst_ni pulsed low (async, mid-cycle), then PC_o=RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer with hardware return stack, interrupt
// entry/exit and zero/carry save-restore across interrupts.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   ST_RUN | normal flow, interrupts enabled (ie=1)
//   ST_ISR | servicing an interrupt, further requests masked until RETI
module pc_sequencer #(
  parameter int              PC_W        = 12,
  parameter int              OFFS_W      = 9,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [3:0]        PCoper_i,
  input  logic              zero_i,
  input  logic              carry_i,
  input  logic [OFFS_W-1:0] offset_i,
  input  logic [PC_W-1:0]   addr_i,
  input  logic [PC_W-1:0]   ISRaddr_i,
  input  logic              irq_i,
  output logic              irq_ack_o,
  output logic [PC_W-1:0]   PC_o,
  output logic              flags_restore_o,
  output logic              zero_rest_o,
  output logic              carry_rest_o,
  output logic              in_isr_o,
  output logic              stack_ovf_o,
  output logic              stack_unf_o
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam int ENT_W = PC_W + 2;

  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [3:0] OP_BZ   = 4'b0100;
  localparam logic [3:0] OP_BNZ  = 4'b0101;
  localparam logic [3:0] OP_BC   = 4'b0110;
  localparam logic [3:0] OP_BNC  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_CALL = 4'b1001;
  localparam logic [3:0] OP_RET  = 4'b1010;
  localparam logic [3:0] OP_RETI = 4'b1011;

  typedef enum logic {ST_RUN, ST_ISR} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              ack_q, ack_d;
  logic              frest_q, frest_d;
  logic              zr_q, zr_d;
  logic              cr_q, cr_d;

  logic [ENT_W-1:0]  stack_q [STACK_DEPTH];
  logic [IDX_W-1:0]  top_idx;
  logic [ENT_W-1:0]  top_entry;
  logic              stack_empty;
  logic              stack_full;

  logic [PC_W-1:0]   off_sext;
  logic [PC_W-1:0]   pc_next;
  logic [PC_W-1:0]   pc_br;
  logic [PC_W-1:0]   seq_pc;
  logic              is_stack_op;
  logic              irq_take;

  logic              want_push;
  logic              want_pop;
  logic              push_we;
  logic [ENT_W-1:0]  push_data;

  assign off_sext    = PC_W'($signed(offset_i));
  assign pc_next     = pc_q + PC_W'(1);
  assign pc_br       = pc_q + off_sext;
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_FULL);
  assign top_idx     = IDX_W'(sp_q - SP_W'(1));
  assign top_entry   = stack_q[top_idx];

  assign is_stack_op = (PCoper_i == OP_CALL) || (PCoper_i == OP_RET) ||
                       (PCoper_i == OP_RETI);
  // Stack ops defer the interrupt so the stack is never pushed/popped twice per edge.
  assign irq_take    = irq_i && (state_q == ST_RUN) && !is_stack_op;

  always_comb begin
    seq_pc = pc_next;
    case (PCoper_i)
      OP_BZ:   if (zero_i)   seq_pc = pc_br;
      OP_BNZ:  if (!zero_i)  seq_pc = pc_br;
      OP_BC:   if (carry_i)  seq_pc = pc_br;
      OP_BNC:  if (!carry_i) seq_pc = pc_br;
      OP_JMP,
      OP_CALL: seq_pc = addr_i;
      OP_RET,
      OP_RETI: if (!stack_empty) seq_pc = top_entry[PC_W-1:0];
      default: seq_pc = pc_next;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ack_d     = 1'b0;
    frest_d   = 1'b0;
    zr_d      = zr_q;
    cr_d      = cr_q;
    want_push = 1'b0;
    want_pop  = 1'b0;
    push_we   = 1'b0;
    push_data = {2'b00, pc_next};

    if (en_i) begin
      pc_d = seq_pc;
      if (irq_take) begin
        pc_d      = ISRaddr_i;
        ack_d     = 1'b1;
        state_d   = ST_ISR;
        want_push = 1'b1;
        push_data = {zero_i, carry_i, seq_pc};
      end else begin
        case (PCoper_i)
          OP_CALL: want_push = 1'b1;
          OP_RET:  want_pop  = 1'b1;
          OP_RETI: begin
            want_pop = 1'b1;
            frest_d  = 1'b1;
            zr_d     = stack_empty ? 1'b0 : top_entry[PC_W+1];
            cr_d     = stack_empty ? 1'b0 : top_entry[PC_W];
            state_d  = ST_RUN;
          end
          default: ;
        endcase
      end

      if (want_push) begin
        if (stack_full) begin
          ovf_d = 1'b1;
        end else begin
          push_we = 1'b1;
          sp_d    = sp_q + SP_W'(1);
        end
      end

      if (want_pop) begin
        if (stack_empty) unf_d = 1'b1;
        else             sp_d  = sp_q - SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ack_q   <= 1'b0;
      frest_q <= 1'b0;
      zr_q    <= 1'b0;
      cr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ack_q   <= ack_d;
      frest_q <= frest_d;
      zr_q    <= zr_d;
      cr_q    <= cr_d;
    end
  end

  // Entry storage needs no reset: a zero pointer makes every entry unreachable.
  always_ff @(posedge clk_i) begin
    if (push_we) stack_q[sp_q[IDX_W-1:0]] <= push_data;
  end

  assign PC_o            = pc_q;
  assign irq_ack_o       = ack_q;
  assign flags_restore_o = frest_q;
  assign zero_rest_o     = zr_q;
  assign carry_rest_o    = cr_q;
  assign in_isr_o        = (state_q == ST_ISR);
  assign stack_ovf_o     = ovf_q;
  assign stack_unf_o     = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected outputs, a
// monitor pops and compares them after each clock edge or reset assertion.
module tb_pc_sequencer;

  localparam int PC_W  = 12;
  localparam int OFF_W = 9;
  localparam int DEPTH = 8;

  localparam logic [3:0] INC  = 4'b0000;
  localparam logic [3:0] BZ   = 4'b0100;
  localparam logic [3:0] BNZ  = 4'b0101;
  localparam logic [3:0] BC   = 4'b0110;
  localparam logic [3:0] BNC  = 4'b0111;
  localparam logic [3:0] JMP  = 4'b1000;
  localparam logic [3:0] CALL = 4'b1001;
  localparam logic [3:0] RET  = 4'b1010;
  localparam logic [3:0] RETI = 4'b1011;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic             en_i = 1'b0;
  logic [3:0]       PCoper_i = '0;
  logic             zero_i = 1'b0;
  logic             carry_i = 1'b0;
  logic [OFF_W-1:0] offset_i = '0;
  logic [PC_W-1:0]  addr_i = '0;
  logic [PC_W-1:0]  ISRaddr_i = 12'h800;
  logic             irq_i = 1'b0;
  logic             irq_ack_o;
  logic [PC_W-1:0]  PC_o;
  logic             flags_restore_o;
  logic             zero_rest_o;
  logic             carry_rest_o;
  logic             in_isr_o;
  logic             stack_ovf_o;
  logic             stack_unf_o;

  pc_sequencer #(
    .PC_W(PC_W), .OFFS_W(OFF_W), .STACK_DEPTH(DEPTH), .RESET_PC(12'h000)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .PCoper_i(PCoper_i),
    .zero_i(zero_i), .carry_i(carry_i), .offset_i(offset_i), .addr_i(addr_i),
    .ISRaddr_i(ISRaddr_i), .irq_i(irq_i), .irq_ack_o(irq_ack_o), .PC_o(PC_o),
    .flags_restore_o(flags_restore_o), .zero_rest_o(zero_rest_o),
    .carry_rest_o(carry_rest_o), .in_isr_o(in_isr_o),
    .stack_ovf_o(stack_ovf_o), .stack_unf_o(stack_unf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string           nm;
    logic [PC_W-1:0] pc;
    logic            ack, fr, zr, cr, isr, ovf, unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push_exp(input string nm, input logic [PC_W-1:0] pc,
                          input logic ack, fr, zr, cr, isr, ovf, unf);
    exp_t e;
    e.nm = nm; e.pc = pc; e.ack = ack; e.fr = fr; e.zr = zr; e.cr = cr;
    e.isr = isr; e.ovf = ovf; e.unf = unf;
    exp_q.push_back(e);
  endtask

  task automatic step(input string nm, input logic en, input logic [3:0] op,
                      input logic z, c, input int off, input logic [PC_W-1:0] ad,
                      input logic irq, input logic [PC_W-1:0] epc,
                      input logic eack, efr, ezr, ecr, eisr, eovf, eunf);
    @(negedge clk_i);
    en_i = en; PCoper_i = op; zero_i = z; carry_i = c;
    offset_i = OFF_W'(off); addr_i = ad; irq_i = irq;
    push_exp(nm, epc, eack, efr, ezr, ecr, eisr, eovf, eunf);
  endtask

  // Monitor: one expectation per queued entry, sampled 1 time unit after the event.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ok = (PC_o === e.pc) && (irq_ack_o === e.ack) &&
             (flags_restore_o === e.fr) && (in_isr_o === e.isr) &&
             (stack_ovf_o === e.ovf) && (stack_unf_o === e.unf);
        if (e.fr) ok = ok && (zero_rest_o === e.zr) && (carry_rest_o === e.cr);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got pc=%h ack=%b fr=%b zr=%b cr=%b isr=%b ovf=%b unf=%b, expected pc=%h ack=%b fr=%b zr=%b cr=%b isr=%b ovf=%b unf=%b",
                      e.nm, PC_o, irq_ack_o, flags_restore_o, zero_rest_o,
                      carry_rest_o, in_isr_o, stack_ovf_o, stack_unf_o,
                      e.pc, e.ack, e.fr, e.zr, e.cr, e.isr, e.ovf, e.unf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    push_exp("reset", 12'h000, 0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    //          name      en op    z c off  addr    irq  pc     ack fr zr cr isr ovf unf
    step("inc1",     1, INC,  0,0,  0, 12'h000, 0, 12'h001, 0,0,0,0,0,0,0);
    step("inc2",     1, INC,  0,0,  0, 12'h000, 0, 12'h002, 0,0,0,0,0,0,0);
    step("inc3",     1, INC,  0,0,  0, 12'h000, 0, 12'h003, 0,0,0,0,0,0,0);
    step("bz_tk",    1, BZ,   1,0, -2, 12'h000, 0, 12'h001, 0,0,0,0,0,0,0);
    step("inc4",     1, INC,  0,0,  0, 12'h000, 0, 12'h002, 0,0,0,0,0,0,0);
    step("inc5",     1, INC,  0,0,  0, 12'h000, 0, 12'h003, 0,0,0,0,0,0,0);
    step("bz_nt",    1, BZ,   0,0, -2, 12'h000, 0, 12'h004, 0,0,0,0,0,0,0);
    step("bnz_tk",   1, BNZ,  0,0,  3, 12'h000, 0, 12'h007, 0,0,0,0,0,0,0);
    step("bc_tk",    1, BC,   0,1, -7, 12'h000, 0, 12'h000, 0,0,0,0,0,0,0);
    step("bnc_nt",   1, BNC,  0,1,  5, 12'h000, 0, 12'h001, 0,0,0,0,0,0,0);
    step("op_undef", 1, 4'b0011, 0,0, 5, 12'h000, 0, 12'h002, 0,0,0,0,0,0,0);
    step("en_hold",  0, JMP,  0,0,  0, 12'h555, 1, 12'h002, 0,0,0,0,0,0,0);

    step("jmp_ffe",  1, JMP,  0,0,  0, 12'hFFE, 0, 12'hFFE, 0,0,0,0,0,0,0);
    step("inc_fff",  1, INC,  0,0,  0, 12'h000, 0, 12'hFFF, 0,0,0,0,0,0,0);
    step("inc_wrap", 1, INC,  0,0,  0, 12'h000, 0, 12'h000, 0,0,0,0,0,0,0);

    step("jmp_010",  1, JMP,  0,0,  0, 12'h010, 0, 12'h010, 0,0,0,0,0,0,0);
    step("call_100", 1, CALL, 0,0,  0, 12'h100, 0, 12'h100, 0,0,0,0,0,0,0);
    step("inc_101",  1, INC,  0,0,  0, 12'h000, 0, 12'h101, 0,0,0,0,0,0,0);
    step("ret_011",  1, RET,  0,0,  0, 12'h000, 0, 12'h011, 0,0,0,0,0,0,0);

    step("jmp_020",  1, JMP,  0,0,  0, 12'h020, 0, 12'h020, 0,0,0,0,0,0,0);
    step("irq_take", 1, BNC,  1,0,  5, 12'h000, 1, 12'h800, 1,0,0,0,1,0,0);
    step("isr_mask", 1, INC,  0,0,  0, 12'h000, 1, 12'h801, 0,0,0,0,1,0,0);
    step("reti_1",   1, RETI, 0,0,  0, 12'h000, 1, 12'h025, 0,1,1,0,0,0,0);
    step("irq_again",1, INC,  0,1,  0, 12'h000, 1, 12'h800, 1,0,0,0,1,0,0);
    step("reti_2",   1, RETI, 1,1,  0, 12'h000, 0, 12'h026, 0,1,0,1,0,0,0);

    step("jmp_040",  1, JMP,  0,0,  0, 12'h040, 0, 12'h040, 0,0,0,0,0,0,0);
    step("call_defer",1, CALL,0,0,  0, 12'h200, 1, 12'h200, 0,0,0,0,0,0,0);
    step("irq_after",1, INC,  1,1,  0, 12'h000, 1, 12'h800, 1,0,0,0,1,0,0);
    step("reti_201", 1, RETI, 0,0,  0, 12'h000, 0, 12'h201, 0,1,1,1,0,0,0);
    step("ret_041",  1, RET,  0,0,  0, 12'h000, 0, 12'h041, 0,0,0,0,0,0,0);

    for (int k = 0; k <= DEPTH; k++)
      step($sformatf("call_ovf%0d", k), 1, CALL, 0,0, 0, 12'h300 + 12'(k*16), 0,
           12'h300 + 12'(k*16), 0,0,0,0,0, (k == DEPTH), 0);
    for (int j = 1; j < DEPTH; j++)
      step($sformatf("ret_pop%0d", j), 1, RET, 0,0, 0, 12'h000, 0,
           12'h300 + 12'((DEPTH-1-j)*16 + 1), 0,0,0,0,0,1,0);
    step("ret_last", 1, RET,  0,0,  0, 12'h000, 0, 12'h042, 0,0,0,0,0,1,0);
    step("ret_unf",  1, RET,  0,0,  0, 12'h000, 0, 12'h043, 0,0,0,0,0,1,1);
    step("reti_emp", 1, RETI, 1,1,  0, 12'h000, 0, 12'h044, 0,1,0,0,0,1,1);
    step("irq_pre",  1, INC,  1,0,  0, 12'h000, 1, 12'h800, 1,0,0,0,1,1,1);
    step("isr_inc",  1, INC,  0,0,  0, 12'h000, 0, 12'h801, 0,0,0,0,1,1,1);

    @(negedge clk_i);
    en_i = 1'b0;
    push_exp("mid_reset", 12'h000, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    step("post_rst", 1, INC,  0,0,  0, 12'h000, 0, 12'h001, 0,0,0,0,0,0,0);
    step("stk_clr",  1, RET,  0,0,  0, 12'h000, 0, 12'h002, 0,0,0,0,0,0,1);

    @(negedge clk_i);
    en_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
